tos_cache: RTL and testbench
============================

# tos_cache

Top-of-stack register cache that sits directly upstream of the EBR-backed data stack. It holds T (top) and N (next) in flip-flops so the Forth core sees both operands with zero read latency. It spills to the single-port backing stack on pushes and refills from it on pops. Each accepted stack primitive is acknowledged with a one-cycle `ack` pulse.

## Interface
Parameters:
- `DEPTH`, 64, backing stack entries; total capacity is DEPTH+2.
- `DSZ`, 32, data width.
- `SSZ`, $clog2(DEPTH), backing address width.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `en`  in  1  enable; when low, requests are not accepted and state holds.
- `req`  in  1  request strobe; sampled only when `ready` is high.
- `op`  in  3  primitive: 0 NOP, 1 PUSH, 2 DROP, 3 DUP, 4 SWAP, 5 OVER, 6 BIN, 7 LOAD.
- `vi`  in  DSZ  operand for PUSH, LOAD and BIN.
- `ready`  out  1  high in IDLE.
- `ack`  out  1  one-cycle completion pulse.
- `t`, `n`  out  DSZ  cached top and next.
- `depth`  out  SSZ+2  total item count, 0..DEPTH+2.
- `err_under`, `err_over`  out  1  sticky error flags; cleared only by reset.
- `bs_op`  out  2  to backing stack: NOP/PUSH/POP, same encoding as the stack bus.
- `bs_sp`  out  SSZ  backing address.
- `bs_vi`  out  DSZ  spill data.
- `bs_s0`  in  DSZ  fill data; valid by the end of the cycle in which `bs_op`=POP.

## Operation
- Internal backing count `bc` equals max(`depth`-2, 0).
- Shorthand used below: d = `depth`, v = `vi`.
- **Accept rule:** a request is accepted on the edge where `req & ready & en`.
- **PUSH** (needs d < DEPTH+2): N←T, T←v, d+1.
  - If d ≥ 2: spill the old N. In the accept cycle drive `bs_op`=PUSH, `bs_sp`=`bc`, `bs_vi`=N; then `bc`+1.
- **DUP** (needs 1 ≤ d < DEPTH+2): N←T, d+1. Spills exactly as PUSH does.
- **OVER** (needs 2 ≤ d < DEPTH+2): N←T, T←N, d+1. Spills exactly as PUSH does.
- **SWAP** (needs d ≥ 2): T↔N. No backing traffic.
- **LOAD** (needs d ≥ 1): T←v. No depth change.
- **DROP** (needs d ≥ 1): T←N, d-1.
- **BIN** (needs d ≥ 2): T←v, d-1. This is the ALU result replacing the T,N pair.
- **Fill:** DROP and BIN need a fill if `bc` > 0 at accept.
  - On accept, decrement `bc` and enter FILL.
  - In FILL, drive `bs_op`=POP and `bs_sp`=new `bc`.
  - At the end of FILL, N←`bs_s0`.
  - If `bc`=0, N is cleared to 0 whenever d drops below 2.
- **NOP:** no state change; `ack` still pulses.
- **Illegal requests:** a request violating its depth precondition changes no T/N/d/backing state. It sets `err_over` (PUSH/DUP/OVER when full) or `err_under` (all other violations), and is still acked.
- **FSM states:** IDLE, FILL.
  - IDLE→FILL on an accepted fill op.
  - FILL→IDLE unconditionally after one cycle.
  - `ready` = (state==IDLE).
- **Backing bus:** `bs_op`=NOP in every cycle not listed above.
- Arithmetic is unsigned modulo on `bc` and d. Range checks guarantee neither counter wraps.

## Timing
- **Reset values:** `t`=0, `n`=0, `depth`=0, `bc`=0, state IDLE, `ready`=1, `ack`=0, `err_*`=0, `bs_op`=NOP, `bs_sp`=0, `bs_vi`=0.
- **Non-fill ops:** T/N/d update at the accept edge; `ack` is high the following cycle. Throughput is one per cycle; `ready` stays high.
- **Fill ops:** T and d update at the accept edge; N updates at the end of FILL. `ack` is high the cycle after FILL, i.e. 2 cycles after accept. `ready` is low during FILL, and `req` is ignored there.
- **`en` low during FILL:** FSM and N freeze; `bs_op` stays POP; FILL completes on the first enabled cycle.
- **Reset mid-FILL:** returns immediately to reset values; no `ack`.
- **Output timing:** `ack` is registered. `bs_*` are combinational from state/`op`/`req`.

## Test plan
- **Reset and single push:** reset, then PUSH 5 → next cycle `t`=5, `n`=0, `depth`=1, `ack`=1, `bs_op` stays NOP.
- **Spill path:** PUSH 1, 2, 3 → on the third accept `bs_op`=PUSH, `bs_sp`=0, `bs_vi`=1. Afterwards `t`=3, `n`=2, `depth`=3.
- **Fill path:** from the spill state, DROP → `ready` low for 1 cycle; FILL drives `bs_op`=POP, `bs_sp`=0; `bs_s0`=1 is returned. Ack arrives 2 cycles after accept with `t`=2, `n`=1, `depth`=2.
- **BIN/SWAP/OVER:** with stack 7 9 (T=9), SWAP → `t`=7, `n`=9. OVER → `t`=9, `n`=7, `depth`=3. BIN vi=16 → `t`=16, `n`=9, `depth`=2.
- **Boundaries:** DROP on empty → `err_under`=1, `depth`=0, ack. Fill to DEPTH+2 then PUSH → `err_over`=1, no `bs_op`=PUSH, depth unchanged.
- **Reset mid-FILL:** assert `rst` low during FILL → all outputs at reset values, no `ack`, `bs_op`=NOP.

Source files
------------

// File: rtl/tos_cache.sv
// tos_cache: T/N register cache in front of a single-port backing data stack
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   en_i, req_i, op_i, vi_i request handshake, primitive and operand
//   ready_o, ack_o          idle indication, one-cycle completion pulse
//   t_o, n_o, depth_o       cached top/next and total item count
//   err_under_o, err_over_o sticky error flags
//   bs_op_o, bs_sp_o, bs_vi_o, bs_s0_i  backing stack bus
module tos_cache #(
  parameter int DEPTH = 64,
  parameter int DSZ   = 32,
  parameter int SSZ   = $clog2(DEPTH)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           en_i,
  input  logic           req_i,
  input  logic [2:0]     op_i,
  input  logic [DSZ-1:0] vi_i,
  output logic           ready_o,
  output logic           ack_o,
  output logic [DSZ-1:0] t_o,
  output logic [DSZ-1:0] n_o,
  output logic [SSZ+1:0] depth_o,
  output logic           err_under_o,
  output logic           err_over_o,
  output logic [1:0]     bs_op_o,
  output logic [SSZ-1:0] bs_sp_o,
  output logic [DSZ-1:0] bs_vi_o,
  input  logic [DSZ-1:0] bs_s0_i
);
  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, DROP = 3'd2, DUP = 3'd3;
  localparam logic [2:0] SWAP = 3'd4, OVER = 3'd5, BIN = 3'd6, LOAD = 3'd7;
  localparam logic [SSZ+1:0] ONE = (SSZ+2)'(1), TWO = (SSZ+2)'(2), FULL = (SSZ+2)'(DEPTH+2);
  typedef enum logic {IDLE, FILL} state_e;
  state_e state_q, state_d;
  logic [DSZ-1:0] t_q, t_d, n_q, n_d;
  logic [SSZ+1:0] d_q, d_d, need;
  logic ack_q, ack_d, eu_q, eu_d, eo_q, eo_d;
  logic acc, grow, shrink, over, legal, spill, fill;
  logic [SSZ-1:0] bc;
  assign acc    = req_i & en_i & (state_q == IDLE);
  assign grow   = op_i == PUSH || op_i == DUP || op_i == OVER;
  assign shrink = op_i == DROP || op_i == BIN;
  assign need   = (op_i == OVER || op_i == SWAP || op_i == BIN) ? TWO :
                  (op_i == DUP || op_i == LOAD || op_i == DROP) ? ONE : '0;
  assign over   = grow && d_q == FULL;
  assign legal  = d_q >= need && !over;
  assign spill  = acc & legal & grow & (d_q >= TWO);
  assign fill   = acc & legal & shrink & (d_q > TWO);
  // backing count is implied by depth; in FILL depth has already been decremented
  assign bc     = d_q >= TWO ? SSZ'(d_q - TWO) : '0;
  assign bs_op_o = state_q == FILL ? 2'd2 : spill ? 2'd1 : 2'd0;
  assign bs_sp_o = (state_q == FILL || spill) ? bc : '0;
  assign bs_vi_o = spill ? n_q : '0;
  assign ready_o     = state_q == IDLE;
  assign ack_o       = ack_q;
  assign t_o         = t_q;
  assign n_o         = n_q;
  assign depth_o     = d_q;
  assign err_under_o = eu_q;
  assign err_over_o  = eo_q;
  always_comb begin
    state_d = state_q;
    t_d = t_q;
    n_d = n_q;
    d_d = d_q;
    ack_d = 1'b0;
    eu_d = eu_q;
    eo_d = eo_q;
    if (state_q == FILL) begin
      if (en_i) begin
        n_d = bs_s0_i;
        state_d = IDLE;
        ack_d = 1'b1;
      end
    end else if (acc) begin
      ack_d = !fill;
      if (!legal) begin
        eo_d = eo_q | over;
        eu_d = eu_q | !over;
      end else begin
        case (op_i)
          PUSH: begin n_d = t_q; t_d = vi_i; d_d = d_q + ONE; end
          DUP:  begin n_d = t_q; d_d = d_q + ONE; end
          OVER: begin n_d = t_q; t_d = n_q; d_d = d_q + ONE; end
          SWAP: begin n_d = t_q; t_d = n_q; end
          LOAD: t_d = vi_i;
          DROP, BIN: begin
            t_d = op_i == BIN ? vi_i : n_q;
            d_d = d_q - ONE;
            // N is kept until the refill lands, or cleared once nothing is below T
            n_d = d_q > TWO ? n_q : '0;
            state_d = fill ? FILL : IDLE;
          end
          default: ;
        endcase
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      t_q <= '0;
      n_q <= '0;
      d_q <= '0;
      ack_q <= 1'b0;
      eu_q <= 1'b0;
      eo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      n_q <= n_d;
      d_q <= d_d;
      ack_q <= ack_d;
      eu_q <= eu_d;
      eo_q <= eo_d;
    end
  end
endmodule

// File: tb/tb_tos_cache.sv
// tb_tos_cache: directed table-driven bench for tos_cache with a backing stack model
module tb_tos_cache;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, req = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] vi = '0, t, n, bs_vi, bs_s0;
  logic [7:0] depth;
  logic [5:0] bs_sp;
  logic [1:0] bs_op;
  logic ready, ack, eu, eo;
  logic [31:0] mem [64];
  int checks = 0, errors = 0;
  typedef struct {
    logic [2:0] op; logic [31:0] vi; bit fill;
    logic [1:0] bop; logic [5:0] bsp; logic [31:0] bvi;
    logic [31:0] et; logic [31:0] en_; logic [7:0] ed; bit eu;
  } vec_t;
  vec_t v[22];
  tos_cache dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .req_i(req), .op_i(op), .vi_i(vi),
    .ready_o(ready), .ack_o(ack), .t_o(t), .n_o(n), .depth_o(depth),
    .err_under_o(eu), .err_over_o(eo),
    .bs_op_o(bs_op), .bs_sp_o(bs_sp), .bs_vi_o(bs_vi), .bs_s0_i(bs_s0)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (bs_op == 2'd1) mem[bs_sp] <= bs_vi;
  assign bs_s0 = mem[bs_sp];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(logic [2:0] o, logic [31:0] x, bit f, logic [1:0] bo,
                              logic [5:0] bs, logic [31:0] bv, logic [31:0] et,
                              logic [31:0] en_, logic [7:0] ed, bit e);
    vec_t r;
    r.op = o; r.vi = x; r.fill = f; r.bop = bo; r.bsp = bs; r.bvi = bv;
    r.et = et; r.en_ = en_; r.ed = ed; r.eu = e;
    return r;
  endfunction
  task automatic run(vec_t x, int i);
    @(negedge clk);
    req = 1'b1; op = x.op; vi = x.vi;
    #1;
    chk($sformatf("v%0d acc bs_op", i), bs_op, x.bop);
    chk($sformatf("v%0d acc bs_sp", i), bs_sp, x.fill ? 6'd0 : x.bsp);
    chk($sformatf("v%0d acc bs_vi", i), bs_vi, x.bvi);
    @(negedge clk);
    req = 1'b0;
    #1;
    if (x.fill) begin
      chk($sformatf("v%0d fill ready", i), ready, 0);
      chk($sformatf("v%0d fill ack", i), ack, 0);
      chk($sformatf("v%0d fill bs_op", i), bs_op, 2);
      chk($sformatf("v%0d fill bs_sp", i), bs_sp, x.bsp);
      @(negedge clk);
      #1;
    end
    chk($sformatf("v%0d ack", i), ack, 1);
    chk($sformatf("v%0d ready", i), ready, 1);
    chk($sformatf("v%0d t", i), t, x.et);
    chk($sformatf("v%0d n", i), n, x.en_);
    chk($sformatf("v%0d depth", i), depth, x.ed);
    chk($sformatf("v%0d err_under", i), eu, x.eu);
    chk($sformatf("v%0d err_over", i), eo, 0);
  endtask
  task automatic chk_reset(string tag);
    chk({tag, " t"}, t, 0);
    chk({tag, " n"}, n, 0);
    chk({tag, " depth"}, depth, 0);
    chk({tag, " ready"}, ready, 1);
    chk({tag, " ack"}, ack, 0);
    chk({tag, " err_under"}, eu, 0);
    chk({tag, " err_over"}, eo, 0);
    chk({tag, " bs_op"}, bs_op, 0);
    chk({tag, " bs_sp"}, bs_sp, 0);
    chk({tag, " bs_vi"}, bs_vi, 0);
  endtask
  initial begin
    //          op    vi  fill bop bsp bvi  t   n   d  eu
    v[0]  = mk(3'd1, 5,  0, 0, 0, 0, 5,  0,  1, 0);
    v[1]  = mk(3'd2, 0,  0, 0, 0, 0, 0,  0,  0, 0);
    v[2]  = mk(3'd1, 1,  0, 0, 0, 0, 1,  0,  1, 0);
    v[3]  = mk(3'd1, 2,  0, 0, 0, 0, 2,  1,  2, 0);
    v[4]  = mk(3'd1, 3,  0, 1, 0, 1, 3,  2,  3, 0);
    v[5]  = mk(3'd2, 0,  1, 0, 0, 0, 2,  1,  2, 0);
    v[6]  = mk(3'd7, 9,  0, 0, 0, 0, 9,  1,  2, 0);
    v[7]  = mk(3'd2, 0,  0, 0, 0, 0, 1,  0,  1, 0);
    v[8]  = mk(3'd7, 7,  0, 0, 0, 0, 7,  0,  1, 0);
    v[9]  = mk(3'd1, 9,  0, 0, 0, 0, 9,  7,  2, 0);
    v[10] = mk(3'd4, 0,  0, 0, 0, 0, 7,  9,  2, 0);
    v[11] = mk(3'd5, 0,  0, 1, 0, 9, 9,  7,  3, 0);
    v[12] = mk(3'd6, 16, 1, 0, 0, 0, 16, 9,  2, 0);
    v[13] = mk(3'd3, 0,  0, 1, 0, 9, 16, 16, 3, 0);
    v[14] = mk(3'd6, 3,  1, 0, 0, 0, 3,  9,  2, 0);
    v[15] = mk(3'd6, 4,  0, 0, 0, 0, 4,  0,  1, 0);
    v[16] = mk(3'd0, 0,  0, 0, 0, 0, 4,  0,  1, 0);
    v[17] = mk(3'd3, 0,  0, 0, 0, 0, 4,  4,  2, 0);
    v[18] = mk(3'd2, 0,  0, 0, 0, 0, 4,  0,  1, 0);
    v[19] = mk(3'd5, 0,  0, 0, 0, 0, 4,  0,  1, 1);
    v[20] = mk(3'd2, 0,  0, 0, 0, 0, 0,  0,  0, 1);
    v[21] = mk(3'd2, 0,  0, 0, 0, 0, 0,  0,  0, 1);
    repeat (2) @(negedge clk);
    #1;
    chk_reset("in reset");
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk_reset("after reset");
    for (int i = 0; i < 22; i++) run(v[i], i);
    for (int i = 1; i <= 66; i++) begin
      @(negedge clk);
      req = 1'b1; op = 3'd1; vi = i;
      #1;
      if (i == 66) begin
        chk("last spill bs_op", bs_op, 1);
        chk("last spill bs_sp", bs_sp, 63);
        chk("last spill bs_vi", bs_vi, 64);
      end
      @(negedge clk);
      req = 1'b0;
    end
    #1;
    chk("full t", t, 66);
    chk("full n", n, 65);
    chk("full depth", depth, 66);
    chk("full err_over", eo, 0);
    @(negedge clk);
    req = 1'b1; op = 3'd1; vi = 99;
    #1;
    chk("overflow bs_op", bs_op, 0);
    @(negedge clk);
    req = 1'b0;
    #1;
    chk("overflow err_over", eo, 1);
    chk("overflow ack", ack, 1);
    chk("overflow depth", depth, 66);
    chk("overflow t", t, 66);
    @(negedge clk);
    req = 1'b1; op = 3'd2;
    @(negedge clk);
    req = 1'b0; en = 1'b0;
    #1;
    chk("stall ready", ready, 0);
    chk("stall bs_op", bs_op, 2);
    chk("stall bs_sp", bs_sp, 63);
    chk("stall t", t, 65);
    chk("stall depth", depth, 65);
    @(negedge clk);
    #1;
    chk("stall held bs_op", bs_op, 2);
    chk("stall held ready", ready, 0);
    chk("stall held ack", ack, 0);
    en = 1'b1;
    @(negedge clk);
    #1;
    chk("stall done ack", ack, 1);
    chk("stall done n", n, 64);
    chk("stall done ready", ready, 1);
    @(negedge clk);
    req = 1'b1; op = 3'd2;
    @(negedge clk);
    req = 1'b0;
    #1;
    chk("rstfill bs_op", bs_op, 2);
    chk("rstfill bs_sp", bs_sp, 62);
    rst_n = 1'b0;
    #1;
    chk_reset("mid-fill reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk_reset("post mid-fill reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
